sram_port_arbiter: RTL

Arbitrates the single read/write port (port 0) of one `sky130_sram_2kbyte_1rw1r_32x512_8` macro between the core and the UART Wishbone bridge. It sits between the two masters and the SRAM; one instance is placed per memory (instruction and data). The block replaces the combinational mux with a registered grant FSM. It generates a real Wishbone ack aligned to the SRAM's one-cycle read latency, and stalls the core while the UART owns the port.

---
 rtl/osiris_mem_pkg.sv | 22 ++
 rtl/sram_port_arbiter_if.sv | 34 +++
 rtl/sram_port_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/osiris_mem_pkg.sv
// -----------------------------------------------------------------------------
// osiris_mem_pkg
// Shared definitions for the SRAM port arbiters (one per instruction/data
// memory): macro geometry and the grant FSM state encoding.
// -----------------------------------------------------------------------------
package osiris_mem_pkg;

    // sky130_sram_2kbyte_1rw1r_32x512_8 geometry.
    localparam int SRAM_WORDS   = 512;
    localparam int SRAM_WMASK_W = 4;

    // CORE: core owns port 0. GRANT: UART access issued to the SRAM.
    // ACK: UART read data on the SRAM outputs, ack driven.
    // HOLD: UART bus cycle still open, waiting for next strobe or cyc drop.
    typedef enum logic [1:0] {
        ST_CORE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter_if
// Wishbone classic slave-side bundle between the UART bridge (master) and the
// SRAM port arbiter (slave). Request is already gated by memory select.
//   wb_cyc_i/wb_stb_i/wb_we_i : bus cycle, strobe, write enable   (master->slave)
//   wb_adr_i                  : word address                      (master->slave)
//   wb_dat_i / wb_sel_i       : write data / byte enables         (master->slave)
//   wb_dat_o / wb_ack_o       : read data / acknowledge           (slave->master)
// -----------------------------------------------------------------------------
interface sram_port_arbiter_if
    import osiris_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = $clog2(SRAM_WORDS),
    parameter int DATA_WIDTH = 32
);
    logic                    wb_cyc_i;
    logic                    wb_stb_i;
    logic                    wb_we_i;
    logic [ADDR_WIDTH-1:0]   wb_adr_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [SRAM_WMASK_W-1:0] wb_sel_i;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic                    wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
// Shares the read/write port 0 of one SRAM macro between the core and the
// UART Wishbone bridge. The core has the port by default with zero added
// latency; a UART strobe is latched, issued to the SRAM one cycle later, and
// acked in the cycle its read data appears. The core is stalled while the
// UART owns the port.
// Ports:
//   clk, rst_n        : clock (also SRAM clk0), async active-low reset
//   wb                : Wishbone slave (sram_port_arbiter_if.slave)
//   core_*_i          : core access request (en, we, adr, dat, wmask)
//   core_dat_o        : core read data, held stable across stalls
//   core_stall_o      : freeze core pipeline
//   sram_*0_o / _i    : SRAM port 0 pins (csb/web active low)
// -----------------------------------------------------------------------------
module sram_port_arbiter
    import osiris_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = $clog2(SRAM_WORDS),
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sram_port_arbiter_if.slave      wb,
    input  logic                    core_en_i,
    input  logic                    core_we_i,
    input  logic [ADDR_WIDTH-1:0]   core_adr_i,
    input  logic [DATA_WIDTH-1:0]   core_dat_i,
    input  logic [SRAM_WMASK_W-1:0] core_wmask_i,
    output logic [DATA_WIDTH-1:0]   core_dat_o,
    output logic                    core_stall_o,
    output logic                    sram_csb0_o,
    output logic                    sram_web0_o,
    output logic [SRAM_WMASK_W-1:0] sram_wmask0_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr0_o,
    output logic [DATA_WIDTH-1:0]   sram_din0_o,
    input  logic [DATA_WIDTH-1:0]   sram_dout0_i
);

    arb_state_e              state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   adr_q,       adr_d;
    logic [DATA_WIDTH-1:0]   dat_q,       dat_d;
    logic [SRAM_WMASK_W-1:0] sel_q,       sel_d;
    logic                    we_q,        we_d;
    logic                    prev_core_q, prev_core_d;
    logic [DATA_WIDTH-1:0]   rdata_q,     rdata_d;
    logic                    csb;
    logic                    accept;

    // NOTE: every output of this block gets a default before the case so
    // no path through it can leave a variable unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        sel_d         = sel_q;
        we_d          = we_q;
        accept        = 1'b0;
        csb           = 1'b1;
        sram_web0_o   = 1'b1;
        sram_addr0_o  = core_adr_i;
        sram_din0_o   = core_dat_i;
        sram_wmask0_o = core_wmask_i;
        wb.wb_ack_o   = 1'b0;
        wb.wb_dat_o   = '0;

        unique case (state_q)
            ST_CORE: begin
                // A simultaneous core access still goes out this cycle; the
                // UART request is only latched and served next cycle.
                csb         = ~core_en_i;
                sram_web0_o = ~(core_en_i & core_we_i);
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    accept  = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Latched access always completes, even if cyc has dropped.
                csb           = 1'b0;
                sram_web0_o   = ~we_q;
                sram_addr0_o  = adr_q;
                sram_din0_o   = dat_q;
                sram_wmask0_o = sel_q;
                state_d       = ST_ACK;
            end
            ST_ACK: begin
                wb.wb_ack_o = wb.wb_cyc_i;
                wb.wb_dat_o = sram_dout0_i;
                state_d     = wb.wb_cyc_i ? ST_HOLD : ST_CORE;
            end
            ST_HOLD: begin
                if (!wb.wb_cyc_i) begin
                    state_d = ST_CORE;
                end else if (wb.wb_stb_i) begin
                    accept  = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            default: state_d = ST_CORE;
        endcase

        if (accept) begin
            adr_d = wb.wb_adr_i;
            dat_d = wb.wb_dat_i;
            sel_d = wb.wb_sel_i;
            we_d  = wb.wb_we_i;
        end
    end

    // Only a core read performed in CORE refreshes the core's read register;
    // UART traffic on the shared dout never disturbs it.
    assign prev_core_d  = (state_q == ST_CORE) && core_en_i && !core_we_i;
    assign rdata_d      = prev_core_q ? sram_dout0_i : rdata_q;
    assign core_dat_o   = prev_core_q ? sram_dout0_i : rdata_q;

    // Decoded from the state register only: no path from the Wishbone inputs.
    assign core_stall_o = (state_q != ST_CORE);

    // Deselect the macro while reset is held, whatever the core is driving.
    assign sram_csb0_o  = csb | ~rst_n;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge _d value, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CORE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            prev_core_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            prev_core_q <= prev_core_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule
